fighter_action_sequencer: RTL
=============================

Name: fighter_action_sequencer

Overview:
Conditions the six joystick/button inputs (2-FF synchronise plus debounce) and sequences fighter actions. Attack and parry each run through a timed active/recovery window, with a one-deep combo buffer, and are issued as valid/ready action commands to the game-logic block. Movement is output as a level vector that is suppressed while an action is in progress. It sits between the board pins and the fighter state/render logic, and replaces direct pin-to-LED wiring.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before a clean level changes (10 ms at 100 MHz)
ATTACK_ACTIVE, 16, cycles spent in ATK_ACTIVE
ATTACK_RECOVER, 32, minimum cycles spent in ATK_RECOVER
PARRY_ACTIVE, 8, cycles spent in PRY_ACTIVE
PARRY_RECOVER, 24, minimum cycles spent in PRY_RECOVER

Ports:
clk  input  1  main clock
reset  input  1  asynchronous, active-high reset
left, right, up, down  input  1 each  raw joystick directions, active-high
attack  input  1  raw attack button, active-high
pery  input  1  raw parry button, active-high
move_dir  output  4  {down,up,right,left} conditioned movement
action_code  output  2  0=none, 1=attack, 2=parry
action_valid  output  1  action command valid
action_ready  input  1  consumer accepts the command
busy  output  1  high in any state other than IDLE
phase  output  2  0 idle, 1 active, 2 recover
led_outputs  output  7  {pery,attack,down,up,right,left clean levels, busy}

Behaviour:
- Reset (async, active-high) clears every register:
  - clean levels 0, debounce counters 0, state IDLE, combo buffer empty
  - action_valid 0, action_code 0, move_dir 0, busy 0, phase 0, led_outputs 0
- Conditioning, per input:
  - 2-FF synchroniser.
  - Counter increments while synced != clean and is zeroed when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and synced still differs, clean takes the synced value on the next edge and the counter clears.
  - A raw change held long enough changes clean DEBOUNCE_CYCLES+2 cycles after it is first sampled.
  - Glitches shorter than DEBOUNCE_CYCLES never reach clean.
- Edge detect: a rise is clean=1 with the previous clean=0. Only attack and pery use edges.
- move_dir:
  - Taken from the clean levels in IDLE.
  - Forced to 0 in every other state.
  - left and right both high: both bits 0. Same rule for up and down.
- FSM states: IDLE, ATK_ACTIVE, ATK_RECOVER, PRY_ACTIVE, PRY_RECOVER. A down-counter loads on every state entry.
- IDLE:
  - pery rise goes to PRY_ACTIVE.
  - attack rise goes to ATK_ACTIVE.
  - If both rise in the same cycle, parry wins and the attack rise is discarded.
- Entering either ACTIVE state (the same edge as the state change):
  - action_valid goes to 1 and action_code is set (1 or 2).
  - Raw-to-valid latency is DEBOUNCE_CYCLES+3 cycles.
- Handshake:
  - action_valid and action_code hold until a cycle where action_valid && action_ready.
  - On the next edge action_valid goes to 0 and action_code goes to 0.
  - action_ready is ignored while action_valid is 0.
- ACTIVE: stays the parameter count, then moves to the matching RECOVER. Rises during ACTIVE are dropped.
- RECOVER:
  - Stays at least the parameter count.
  - Exit also requires action_valid==0; it stalls in RECOVER until the handshake completes.
  - The first attack or pery rise during RECOVER is stored in the combo buffer. Later rises are dropped, and a same-cycle double rise stores parry.
- RECOVER exit:
  - If the buffer is full, go directly to that ACTIVE state, clear the buffer and issue a new command. There is no IDLE cycle.
  - Otherwise go to IDLE.
- phase and busy are decoded combinationally from the state register.
- Reset asserted mid-action: everything returns to its reset values immediately, and any pending command is lost.

Test Plan:
1. Parameters 4/3/5/2/4, attack held high: action_valid=1 with code 1 at cycle 7 after the raw rise; phase=1 for 3 cycles, then phase=2 for 5 cycles; action_ready=1 throughout; back to IDLE and busy=0 at cycle 15.
2. Attack pulse of 3 cycles, shorter than DEBOUNCE_CYCLES=4 -> clean never rises, action_valid stays 0, led_outputs[5]=0.
3. Attack and pery rise in the same cycle -> a single command with code 2 and phase sequence 2-cycle active then 4-cycle recover; no attack command follows.
4. action_ready held 0 for 20 cycles -> FSM sits in PRY_RECOVER with action_valid=1 and code 2; one cycle after ready=1, valid=0; IDLE follows on the next edge.
5. Attack pressed again during ATK_RECOVER -> a second code-1 command issues directly on RECOVER exit with no IDLE cycle; move_dir=0 throughout even with left held.
6. Left and right held together in IDLE -> move_dir[1:0]=0. Then reset asserted during ATK_ACTIVE -> all outputs are 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/fighter_action_sequencer.sv
// Conditions six raw joystick/button pins and sequences attack/parry actions
// through timed active/recovery windows with a one-deep combo buffer.
module fighter_action_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ATTACK_ACTIVE   = 16,
  parameter int ATTACK_RECOVER  = 32,
  parameter int PARRY_ACTIVE    = 8,
  parameter int PARRY_RECOVER   = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic       attack,
  input  logic       pery,
  output logic [3:0] move_dir,
  output logic [1:0] action_code,
  output logic       action_valid,
  input  logic       action_ready,
  output logic       busy,
  output logic [1:0] phase,
  output logic [6:0] led_outputs
);

  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMAX_A = (ATTACK_ACTIVE > ATTACK_RECOVER) ? ATTACK_ACTIVE : ATTACK_RECOVER;
  localparam int TMAX_P = (PARRY_ACTIVE > PARRY_RECOVER) ? PARRY_ACTIVE : PARRY_RECOVER;
  localparam int TMAX   = (TMAX_A > TMAX_P) ? TMAX_A : TMAX_P;
  localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] T_ATK_ACT = TW'(ATTACK_ACTIVE - 1);
  localparam logic [TW-1:0] T_ATK_REC = TW'(ATTACK_RECOVER - 1);
  localparam logic [TW-1:0] T_PRY_ACT = TW'(PARRY_ACTIVE - 1);
  localparam logic [TW-1:0] T_PRY_REC = TW'(PARRY_RECOVER - 1);

  localparam logic [1:0] CODE_NONE   = 2'd0;
  localparam logic [1:0] CODE_ATTACK = 2'd1;
  localparam logic [1:0] CODE_PARRY  = 2'd2;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ATK_ACTIVE  = 3'd1,
    ATK_RECOVER = 3'd2,
    PRY_ACTIVE  = 3'd3,
    PRY_RECOVER = 3'd4
  } state_t;

  // Bit order {pery, attack, down, up, right, left} throughout.
  logic [5:0]    raw;
  logic [5:0]    sync1;
  logic [5:0]    sync2;
  logic [5:0]    clean;
  logic [DW-1:0] deb_cnt [6];

  state_t        state;
  logic [TW-1:0] timer;
  logic          combo_full;
  logic          combo_parry;
  logic          prev_attack;
  logic          prev_pery;
  logic          attack_rise;
  logic          pery_rise;
  logic [1:0]    lr_dir;
  logic [1:0]    ud_dir;

  assign raw = {pery, attack, down, up, right, left};

  // Two-flop synchroniser and per-input stability counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 6'b000000;
      sync2 <= 6'b000000;
      clean <= 6'b000000;
      for (int i = 0; i < 6; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 6; i++) begin
        if (sync2[i] == clean[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          clean[i]   <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign attack_rise = clean[4] & ~prev_attack;
  assign pery_rise   = clean[5] & ~prev_pery;

  // Action sequencer: state, window timer, combo buffer and command handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      combo_full   <= 1'b0;
      combo_parry  <= 1'b0;
      prev_attack  <= 1'b0;
      prev_pery    <= 1'b0;
      action_valid <= 1'b0;
      action_code  <= CODE_NONE;
    end else begin
      prev_attack <= clean[4];
      prev_pery   <= clean[5];
      if (action_valid && action_ready) begin
        action_valid <= 1'b0;
        action_code  <= CODE_NONE;
      end
      case (state)
        IDLE: begin
          // Parry takes priority when both buttons rise together.
          if (pery_rise) begin
            state        <= PRY_ACTIVE;
            timer        <= T_PRY_ACT;
            action_valid <= 1'b1;
            action_code  <= CODE_PARRY;
          end else if (attack_rise) begin
            state        <= ATK_ACTIVE;
            timer        <= T_ATK_ACT;
            action_valid <= 1'b1;
            action_code  <= CODE_ATTACK;
          end
        end
        ATK_ACTIVE: begin
          if (timer == '0) begin
            state <= ATK_RECOVER;
            timer <= T_ATK_REC;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        PRY_ACTIVE: begin
          if (timer == '0) begin
            state <= PRY_RECOVER;
            timer <= T_PRY_REC;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        ATK_RECOVER, PRY_RECOVER: begin
          // Leaving needs the window elapsed and the last command accepted.
          if ((timer == '0) && !action_valid) begin
            combo_full <= 1'b0;
            if (combo_full && combo_parry) begin
              state        <= PRY_ACTIVE;
              timer        <= T_PRY_ACT;
              action_valid <= 1'b1;
              action_code  <= CODE_PARRY;
            end else if (combo_full) begin
              state        <= ATK_ACTIVE;
              timer        <= T_ATK_ACT;
              action_valid <= 1'b1;
              action_code  <= CODE_ATTACK;
            end else begin
              state <= IDLE;
            end
          end else begin
            if (timer != '0) begin
              timer <= timer - TW'(1);
            end
            if (!combo_full && (attack_rise || pery_rise)) begin
              combo_full  <= 1'b1;
              combo_parry <= pery_rise;
            end
          end
        end
        default: begin
          state        <= IDLE;
          timer        <= '0;
          combo_full   <= 1'b0;
          action_valid <= 1'b0;
          action_code  <= CODE_NONE;
        end
      endcase
    end
  end

  // Status decode and movement gating, all from registered state.
  always_comb begin
    busy   = (state != IDLE);
    lr_dir = (clean[0] && clean[1]) ? 2'b00 : clean[1:0];
    ud_dir = (clean[2] && clean[3]) ? 2'b00 : clean[3:2];
    case (state)
      IDLE:                     phase = 2'd0;
      ATK_ACTIVE, PRY_ACTIVE:   phase = 2'd1;
      ATK_RECOVER, PRY_RECOVER: phase = 2'd2;
      default:                  phase = 2'd0;
    endcase
    if (state == IDLE) begin
      move_dir = {ud_dir, lr_dir};
    end else begin
      move_dir = 4'b0000;
    end
    led_outputs = {clean, busy};
  end

endmodule
